wb_arbiter: RTL

- Writer side of the core's three-ported register file: sole driver of write port 3 (a3/we3/wd3).
- Merges two writeback sources into one write per cycle:
  - single-cycle ALU results, which cannot stall;
  - variable-latency load (LSU) results, over a valid/ready handshake.
- Buffers losing LSU results in a small FIFO.
- Keeps a pending-load scoreboard that the hazard unit queries for stalls.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_fifo.sv | 78 +++++++
 rtl/wb_arbiter.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared types and constants for the writeback arbiter.
//               Defines the register-address width, default data width,
//               the buffered writeback request record and the source tag
//               that tracks which unit produced the current write.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_ALU  = 2'd1,
        WB_LSU  = 2'd2
    } wb_src_e;

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Circular buffer for LSU writeback requests that lost
//               arbitration. Strict in-order drain.
// Ports       : i_clk, i_rst (async, active-high)
//               i_push / i_push_data : enqueue (ignored when full)
//               i_pop                : dequeue head (ignored when empty)
//               o_head               : current head entry
//               o_full / o_empty     : registered occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
)(
    input  logic    i_clk,
    input  logic    i_rst,
    input  logic    i_push,
    input  wb_req_t i_push_data,
    input  logic    i_pop,
    output wb_req_t o_head,
    output logic    o_full,
    output logic    o_empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_req_t          r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // Storage needs no reset: entries are only visible through the counter.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Sole writer of register-file port 3. Merges single-cycle ALU
//               results (never stalled, highest priority) with LSU results
//               arriving over valid/ready; losing LSU results wait in a FIFO.
//               Maintains a pending-load scoreboard for the hazard unit.
// Ports       : i_clk, i_rst (async, active-high)
//               i_alu_valid/i_alu_rd/i_alu_data        : ALU result
//               i_lsu_valid/o_lsu_ready/i_lsu_rd/i_lsu_data : LSU result
//               i_ld_issue/i_ld_issue_rd               : load issue (sets pending)
//               i_q_a1/i_q_a2 -> o_pend1/o_pend2       : scoreboard queries
//               o_we3/o_a3/o_wd3                       : registered write port
// Options     : WB_LSU_BYPASS_EN - an accepted LSU result is written directly
//               (one cycle latency) when the FIFO is empty and the ALU does
//               not occupy the slot.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int XLEN       = wb_pkg::XLEN,
    parameter int FIFO_DEPTH = 2
)(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_alu_valid,
    input  logic [4:0]      i_alu_rd,
    input  logic [XLEN-1:0] i_alu_data,
    input  logic            i_lsu_valid,
    output logic            o_lsu_ready,
    input  logic [4:0]      i_lsu_rd,
    input  logic [XLEN-1:0] i_lsu_data,
    input  logic            i_ld_issue,
    input  logic [4:0]      i_ld_issue_rd,
    input  logic [4:0]      i_q_a1,
    input  logic [4:0]      i_q_a2,
    output logic            o_pend1,
    output logic            o_pend2,
    output logic            o_we3,
    output logic [4:0]      o_a3,
    output logic [XLEN-1:0] o_wd3
);

    wb_req_t w_lsu_req;
    wb_req_t w_head;
    logic    w_full;
    logic    w_empty;
    logic    w_alu_wr;
    logic    w_lsu_fire;
    logic    w_lsu_keep;
    logic    w_pop;
    logic    w_push;
    logic    w_bypass;
    logic [31:0] w_pend_vec;
    logic [31:0] w_pend_nxt;

    logic            r_we3;
    logic [4:0]      r_a3;
    logic [XLEN-1:0] r_wd3;
    wb_src_e         r_src;
    logic [31:1]     r_pending;

    assign w_lsu_req.rd   = i_lsu_rd;
    assign w_lsu_req.data = i_lsu_data;

    // Ready depends only on registered occupancy, so a pop in a full cycle
    // does not open the handshake combinationally.
    assign o_lsu_ready = !w_full;
    assign w_lsu_fire  = i_lsu_valid && !w_full;
    assign w_lsu_keep  = w_lsu_fire && (i_lsu_rd != 5'd0);

    assign w_alu_wr = i_alu_valid && (i_alu_rd != 5'd0);
    // A valid ALU result owns the slot even when it targets x0.
    assign w_pop    = !i_alu_valid && !w_empty;

`ifdef WB_LSU_BYPASS_EN
    assign w_bypass = w_lsu_keep && w_empty && !i_alu_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push = w_lsu_keep && !w_bypass;

    wb_fifo #(
        .DEPTH       (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (w_push),
        .i_push_data (w_lsu_req),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_we3 <= 1'b0;
            r_a3  <= '0;
            r_wd3 <= '0;
            r_src <= WB_NONE;
        end else if (w_alu_wr) begin
            r_we3 <= 1'b1;
            r_a3  <= i_alu_rd;
            r_wd3 <= i_alu_data;
            r_src <= WB_ALU;
        end else if (w_pop) begin
            r_we3 <= 1'b1;
            r_a3  <= w_head.rd;
            r_wd3 <= w_head.data;
            r_src <= WB_LSU;
        end else if (w_bypass) begin
            r_we3 <= 1'b1;
            r_a3  <= i_lsu_rd;
            r_wd3 <= i_lsu_data;
            r_src <= WB_LSU;
        end else begin
            // Address and data hold; only the enable drops.
            r_we3 <= 1'b0;
            r_src <= WB_NONE;
        end
    end

    assign o_we3 = r_we3;
    assign o_a3  = r_a3;
    assign o_wd3 = r_wd3;

    // Scoreboard: a load clears when its write is on the port; a new issue
    // to the same register in that cycle takes precedence.
    assign w_pend_vec = {r_pending, 1'b0};

    always_comb begin
        w_pend_nxt = w_pend_vec;
        if (r_we3 && (r_src == WB_LSU)) begin
            w_pend_nxt[r_a3] = 1'b0;
        end
        if (i_ld_issue && (i_ld_issue_rd != 5'd0)) begin
            w_pend_nxt[i_ld_issue_rd] = 1'b1;
        end
        w_pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pend_nxt[31:1];
        end
    end

    assign o_pend1 = w_pend_vec[i_q_a1];
    assign o_pend2 = w_pend_vec[i_q_a2];

endmodule
`default_nettype wire
